// File: rtl/pipe_cla_addsub.sv
// pipe_cla_addsub
//   Pipelined carry-lookahead adder/subtractor. The operand is cut into
//   N = WIDTH/BLOCK slices. Each slice is added in its own pipeline stage.
//   The block carry is registered between stages. The last stage also
//   produces the flags and applies optional signed saturation. A global
//   advance enable gives a valid/ready handshake with one operation per
//   cycle and N cycles of latency.
//
// Parameters
//   WIDTH  operand/result width in bits
//   BLOCK  bits per lookahead block and per pipeline stage (divides WIDTH, >= 4)
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operation presented
//   in_ready   pipeline accepts the operation this cycle
//   x, y       operands A and B
//   c0         carry-in for add (ignored when sub=1)
//   sub        1: compute x - y
//   sat        1: saturate the result on signed overflow
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   s          result
//   ovf        raw signed overflow (reported even when saturated)
//   cout       unsigned carry-out of the MSB
//   zero       final s == 0

module pipe_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c0,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             ovf,
    output logic             cout,
    output logic             zero
);

    localparam int N = WIDTH / BLOCK;

    if (((WIDTH % BLOCK) != 0) || (BLOCK < 4)) begin : g_bad_params
        $fatal(1, "pipe_cla_addsub: BLOCK must divide WIDTH and be at least 4");
    end

    // The whole pipeline moves together. It stalls only when a finished result
    // is waiting and the consumer does not take it.
    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // One lookahead block. Carries are formed in sum-of-products form inside
    // each 4-bit group. The carry entering a group comes from the group below.
    // That carry is itself the group generate/propagate lookahead term.
    // A short top group is handled when BLOCK is not a multiple of 4.
    // The result is {carry out, sum}.
    function automatic logic [BLOCK:0] cla_block(input logic [BLOCK-1:0] a,
                                                 input logic [BLOCK-1:0] b,
                                                 input logic             ci);
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             term;
        logic             pp;
        int               gb;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            gb   = (i / 4) * 4;
            term = 1'b0;
            pp   = 1'b1;
            for (int m = i; m >= gb; m--) begin
                term = term | (g[m] & pp);
                pp   = pp & p[m];
            end
            c[i+1] = term | (pp & c[gb]);
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    // Stages 0..N-2. Each one adds its slice and registers the slice sum
    // together with the completed low result and the carry. It also registers
    // the operand bits not yet consumed, so they reach the stage that uses
    // them. y is kept raw and inverted slice by slice under the skewed sub bit.
    for (genvar k = 0; k < N - 1; k++) begin : g_stage
        localparam int REM = WIDTH - (k + 1) * BLOCK;

        logic                     v_r;
        logic                     c_r;
        logic                     sub_r;
        logic                     sat_r;
        logic [(k+1)*BLOCK-1:0]   sum_r;
        logic [REM-1:0]           x_r;
        logic [REM-1:0]           y_r;
        logic [BLOCK:0]           blk;

        if (k == 0) begin : g_head
            assign blk = cla_block(x[BLOCK-1:0], y[BLOCK-1:0] ^ {BLOCK{sub}}, sub | c0);

            // First stage register. It is loaded straight from the ports, and
            // the subtract carry-in of 1 is folded into the first block.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    v_r   <= 1'b0;
                    c_r   <= 1'b0;
                    sub_r <= 1'b0;
                    sat_r <= 1'b0;
                    sum_r <= '0;
                    x_r   <= '0;
                    y_r   <= '0;
                end else if (en) begin
                    v_r   <= in_valid;
                    c_r   <= blk[BLOCK];
                    sub_r <= sub;
                    sat_r <= sat;
                    sum_r <= blk[BLOCK-1:0];
                    x_r   <= x[WIDTH-1:BLOCK];
                    y_r   <= y[WIDTH-1:BLOCK];
                end
            end
        end else begin : g_body
            assign blk = cla_block(g_stage[k-1].x_r[BLOCK-1:0],
                                   g_stage[k-1].y_r[BLOCK-1:0] ^ {BLOCK{g_stage[k-1].sub_r}},
                                   g_stage[k-1].c_r);

            // Middle stage register. The new slice sum is appended above the
            // slices already finished, and the lowest remaining operand slice
            // is dropped.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    v_r   <= 1'b0;
                    c_r   <= 1'b0;
                    sub_r <= 1'b0;
                    sat_r <= 1'b0;
                    sum_r <= '0;
                    x_r   <= '0;
                    y_r   <= '0;
                end else if (en) begin
                    v_r   <= g_stage[k-1].v_r;
                    c_r   <= blk[BLOCK];
                    sub_r <= g_stage[k-1].sub_r;
                    sat_r <= g_stage[k-1].sat_r;
                    sum_r <= {blk[BLOCK-1:0], g_stage[k-1].sum_r};
                    x_r   <= g_stage[k-1].x_r[REM+BLOCK-1:BLOCK];
                    y_r   <= g_stage[k-1].y_r[REM+BLOCK-1:BLOCK];
                end
            end
        end
    end

    // Inputs to the last stage. They come from the ports when the pipeline is
    // a single stage, and from the last intermediate register otherwise.
    logic             last_v;
    logic             last_sat;
    logic             last_ci;
    logic [BLOCK-1:0] last_a;
    logic [BLOCK-1:0] last_b;
    logic [BLOCK:0]   blk_last;
    logic [WIDTH-1:0] raw_sum;

    if (N == 1) begin : g_single
        assign last_v   = in_valid;
        assign last_sat = sat;
        assign last_ci  = sub | c0;
        assign last_a   = x[BLOCK-1:0];
        assign last_b   = y[BLOCK-1:0] ^ {BLOCK{sub}};
        assign raw_sum  = blk_last[BLOCK-1:0];
    end else begin : g_multi
        assign last_v   = g_stage[N-2].v_r;
        assign last_sat = g_stage[N-2].sat_r;
        assign last_ci  = g_stage[N-2].c_r;
        assign last_a   = g_stage[N-2].x_r;
        assign last_b   = g_stage[N-2].y_r ^ {BLOCK{g_stage[N-2].sub_r}};
        assign raw_sum  = {blk_last[BLOCK-1:0], g_stage[N-2].sum_r};
    end

    assign blk_last = cla_block(last_a, last_b, last_ci);

    // The carry into the MSB is recovered from the MSB sum bit. The block
    // function therefore returns only its carry out.
    logic             c_top;
    logic             c_msb;
    logic             ovf_next;
    logic [WIDTH-1:0] sat_value;
    logic [WIDTH-1:0] s_next;

    assign c_top     = blk_last[BLOCK];
    assign c_msb     = last_a[BLOCK-1] ^ last_b[BLOCK-1] ^ blk_last[BLOCK-1];
    assign ovf_next  = c_msb ^ c_top;
    assign sat_value = last_a[BLOCK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
    assign s_next    = (last_sat && ovf_next) ? sat_value : raw_sum;

    // Output register. It holds while the consumer stalls, so the result and
    // flags stay stable until accepted. The zero flag tests the value actually
    // delivered, which is the value after saturation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            s         <= '0;
            ovf       <= 1'b0;
            cout      <= 1'b0;
            zero      <= 1'b0;
        end else if (en) begin
            out_valid <= last_v;
            s         <= s_next;
            ovf       <= ovf_next;
            cout      <= c_top;
            zero      <= (s_next == '0);
        end
    end

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// tb_pipe_cla_addsub
//   Self-checking bench for pipe_cla_addsub. It builds a 32-bit / 8-bit-block
//   instance (4 stages) and a 16-bit / 16-bit-block instance (single stage).
//   Directed vectors come from a table. Separate sequences cover
//   back-pressure, reset during operation and the single-stage case.

module tb_pipe_cla_addsub;

    localparam int NSTG = 4;

    logic        clock = 1'b0;
    logic        reset;

    logic        in_valid, in_ready, c0, sub, sat, out_valid, out_ready, ovf, cout, zero;
    logic [31:0] x, y, s;

    logic        n_in_valid, n_in_ready, n_c0, n_sub, n_sat, n_out_valid, n_out_ready;
    logic        n_ovf, n_cout, n_zero;
    logic [15:0] n_x, n_y, n_s;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] x;
        logic [31:0] y;
        logic        c0;
        logic        sub;
        logic        sat;
        logic [31:0] exp_s;
        logic        exp_ovf;
        logic        exp_cout;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    pipe_cla_addsub #(.WIDTH(32), .BLOCK(8)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .c0(c0), .sub(sub), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .ovf(ovf), .cout(cout), .zero(zero)
    );

    pipe_cla_addsub #(.WIDTH(16), .BLOCK(16)) u_dut_n1 (
        .clock(clock), .reset(reset),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .x(n_x), .y(n_y), .c0(n_c0), .sub(n_sub), .sat(n_sat),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .s(n_s), .ovf(n_ovf), .cout(n_cout), .zero(n_zero)
    );

    // Compare one observed value against its required value and count it.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    // Append one directed vector and its hand-computed results to the table.
    task automatic addVec(input string n, input logic [31:0] ax, input logic [31:0] ay,
                          input logic ac0, input logic asub, input logic asat,
                          input logic [31:0] es, input logic eo, input logic ec, input logic ez);
        vec_t v;
        v.name = n; v.x = ax; v.y = ay; v.c0 = ac0; v.sub = asub; v.sat = asat;
        v.exp_s = es; v.exp_ovf = eo; v.exp_cout = ec; v.exp_zero = ez;
        vecs.push_back(v);
    endtask

    // Issue one operation to the 32-bit instance with out_ready high. Then wait
    // a bounded number of cycles for its result and report the cycle count.
    task automatic applyStimulus(input logic [31:0] ax, input logic [31:0] ay,
                                 input logic ac0, input logic asub, input logic asat,
                                 output int lat);
        x = ax; y = ay; c0 = ac0; sub = asub; sat = asat;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        stepCycle();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            stepCycle();
            lat++;
        end
    endtask

    // Same as applyStimulus, for the single-stage instance.
    task automatic applyStimulusNarrow(input logic [15:0] ax, input logic [15:0] ay,
                                       input logic ac0, input logic asub, input logic asat,
                                       output int lat);
        n_x = ax; n_y = ay; n_c0 = ac0; n_sub = asub; n_sat = asat;
        n_in_valid  = 1'b1;
        n_out_ready = 1'b1;
        stepCycle();
        n_in_valid = 1'b0;
        lat = 1;
        while (n_out_valid !== 1'b1 && lat < 20) begin
            stepCycle();
            lat++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        int          issued;
        int          recv;
        int          cyc;
        logic        stall_prev;
        logic [31:0] s_prev;

        addVec("blk_carry",   32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
        addVec("full_chain",  32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1);
        addVec("sub_5_7",     32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        addVec("sub_ovf_raw", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        addVec("sub_ovf_sat", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0);
        addVec("add_ovf_sat", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
        addVec("add_ovf_raw", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0);
        addVec("sub_equal",   32'h12345678, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1);
        addVec("sub_c0_ign",  32'h0000000A, 32'h00000003, 1'b1, 1'b1, 1'b0, 32'h00000007, 1'b0, 1'b1, 1'b0);
        addVec("add_c0_3blk", 32'h0000FFFF, 32'h00FF0000, 1'b1, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0);
        addVec("neg_sat_nz",  32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0);
        addVec("neg_raw_z",   32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
        addVec("mixed_add",   32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0);
        addVec("sub_0_1",     32'h00000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

        reset = 1'b0;
        in_valid = 1'b0; x = '0; y = '0; c0 = 1'b0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
        n_in_valid = 1'b0; n_x = '0; n_y = '0; n_c0 = 1'b0; n_sub = 1'b0; n_sat = 1'b0; n_out_ready = 1'b1;
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.s", s, 32'd0);
        checkOutput("reset.flags", {29'd0, ovf, cout, zero}, 32'd0);
        checkOutput("reset.n1_out_valid", 32'(n_out_valid), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
        stepCycle();

        $display("[TB] directed vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].c0, vecs[i].sub, vecs[i].sat, lat);
            checkOutput($sformatf("%s.latency", vecs[i].name), 32'(lat), 32'(NSTG));
            checkOutput($sformatf("%s.s", vecs[i].name), s, vecs[i].exp_s);
            checkOutput($sformatf("%s.ovf", vecs[i].name), 32'(ovf), 32'(vecs[i].exp_ovf));
            checkOutput($sformatf("%s.cout", vecs[i].name), 32'(cout), 32'(vecs[i].exp_cout));
            checkOutput($sformatf("%s.zero", vecs[i].name), 32'(zero), 32'(vecs[i].exp_zero));
        end
        stepCycle();

        $display("[TB] back-pressure sequence");
        issued = 0; recv = 0; cyc = 0; stall_prev = 1'b0; s_prev = '0;
        while (recv < 8 && cyc < 60) begin
            out_ready = (cyc % 2 == 0);
            if (issued < 8) begin
                in_valid = 1'b1; x = 32'(issued); y = 32'd100; c0 = 1'b0; sub = 1'b0; sat = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checkOutput("bp.in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (stall_prev) begin
                checkOutput("bp.hold_valid", 32'(out_valid), 32'd1);
                checkOutput("bp.hold_s", s, s_prev);
            end
            if (out_valid && out_ready) begin
                checkOutput("bp.order", s, 32'(100 + recv));
                recv++;
            end
            if (in_valid && in_ready) issued++;
            stall_prev = out_valid && !out_ready;
            s_prev = s;
            @(posedge clock);
            #1;
            cyc++;
        end
        checkOutput("bp.count", 32'(recv), 32'd8);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            checkOutput("bp.no_extra", 32'(out_valid), 32'd0);
        end

        $display("[TB] reset during operation");
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; x = 32'hFFFFFFFF; y = 32'(k + 2); c0 = 1'b0; sub = 1'b0; sat = 1'b0;
            stepCycle();
        end
        in_valid = 1'b0;
        checkOutput("rst.pre_valid", 32'(out_valid), 32'd1);
        checkOutput("rst.pre_s", s, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst.s", s, 32'd0);
        checkOutput("rst.flags", {29'd0, ovf, cout, zero}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            stepCycle();
            checkOutput("rst.no_stale", 32'(out_valid), 32'd0);
        end
        applyStimulus(32'd3, 32'd4, 1'b0, 1'b0, 1'b0, lat);
        checkOutput("rst.fresh_latency", 32'(lat), 32'(NSTG));
        checkOutput("rst.fresh_s", s, 32'd7);
        stepCycle();

        $display("[TB] single-stage configuration");
        applyStimulusNarrow(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, lat);
        checkOutput("n1_sat.latency", 32'(lat), 32'd1);
        checkOutput("n1_sat.s", 32'(n_s), 32'h7FFF);
        checkOutput("n1_sat.ovf", 32'(n_ovf), 32'd1);
        checkOutput("n1_sat.cout", 32'(n_cout), 32'd0);
        applyStimulusNarrow(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat);
        checkOutput("n1_wrap.latency", 32'(lat), 32'd1);
        checkOutput("n1_wrap.s", 32'(n_s), 32'h0000);
        checkOutput("n1_wrap.cout", 32'(n_cout), 32'd1);
        checkOutput("n1_wrap.zero", 32'(n_zero), 32'd1);
        checkOutput("n1_wrap.ovf", 32'(n_ovf), 32'd0);
        applyStimulusNarrow(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, lat);
        checkOutput("n1_subsat.s", 32'(n_s), 32'h8000);
        checkOutput("n1_subsat.ovf", 32'(n_ovf), 32'd1);
        checkOutput("n1_subsat.cout", 32'(n_cout), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
